ram_arbiter: RTL

- Two-requester arbiter that shares one single-port synchronous RAM (1-cycle read latency) between two masters, e.g. the RAM_controller sequencer and a debug/loader port.
- Runs a 4-state FSM per access, with round-robin priority on simultaneous requests.
- Returns read data and a one-cycle acknowledge to the served requester.
- Sits between the requesters and the RAM instance.

---
 rtl/ram_arb_pkg.sv | 14 +
 rtl/rr_pick2.sv | 14 +
 rtl/ram_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the two-requester RAM arbiter.
package ram_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 4;
    localparam int unsigned DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on a tie the requester that was not served last wins.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       sel
);

    always_comb begin
        valid = |req;
        sel   = (req == 2'b11) ? ~last : req[1];
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port synchronous RAM between two requesters, one access per
// four cycles, round-robin on simultaneous requests.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              grant_id,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    state_t state_q, state_d;
    logic   sel_q, sel_d;
    logic   we_q, we_d;
    logic   last_q, last_d;
    logic   valid_c, pick_c;

    logic              ack0_d, ack1_d, busy_d, grant_d, en_d, rwe_d;
    logic [DATA_W-1:0] rdata_d, wdata_d;
    logic [ADDR_W-1:0] addr_d;

    rr_pick2 u_pick (
        .req   ({req1, req0}),
        .last  (last_q),
        .valid (valid_c),
        .sel   (pick_c)
    );

    // Next state and next values of every registered output.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        we_d    = we_q;
        last_d  = last_q;
        grant_d = grant_id;
        addr_d  = ram_addr;
        wdata_d = ram_wdata;
        rdata_d = rdata;
        en_d    = 1'b0;
        rwe_d   = 1'b0;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (valid_c) begin
                    sel_d   = pick_c;
                    we_d    = pick_c ? we1 : we0;
                    addr_d  = pick_c ? addr1 : addr0;
                    wdata_d = pick_c ? wdata1 : wdata0;
                    last_d  = pick_c;
                    grant_d = pick_c;
                    en_d    = 1'b1;
                    rwe_d   = pick_c ? we1 : we0;
                    state_d = ACCESS;
                end
            end
            ACCESS: state_d = RESP;
            RESP: begin
                // RAM read data is valid now; capture it as DONE begins.
                if (!we_q) rdata_d = ram_rdata;
                ack0_d  = ~sel_q;
                ack1_d  = sel_q;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= 1'b0;
            we_q      <= 1'b0;
            last_q    <= 1'b1;
            grant_id  <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            rdata     <= '0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
            last_q    <= last_d;
            grant_id  <= grant_d;
            ram_addr  <= addr_d;
            ram_wdata <= wdata_d;
            rdata     <= rdata_d;
            ram_en    <= en_d;
            ram_we    <= rwe_d;
            ack0      <= ack0_d;
            ack1      <= ack1_d;
            busy      <= busy_d;
        end
    end

endmodule
